// File: rtl/spis_pkg.sv
// Shared types and helpers for the SPIS core: opcode/state enums and ISA decode predicates.
package spis_pkg;

  localparam int unsigned OP_W  = 4;
  localparam int unsigned NIB_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 4'h0, OP_SUB = 4'h1, OP_ADC = 4'h2, OP_SBC = 4'h3,
    OP_XAB = 4'h4, OP_LDI = 4'h5, OP_LD  = 4'h6, OP_LDX = 4'h7,
    OP_ST  = 4'h8, OP_STX = 4'h9, OP_XAC = 4'hA, OP_JEQ = 4'hB,
    OP_JMP = 4'hC, OP_NOT = 4'hD, OP_AND = 4'hE, OP_OR  = 4'hF
  } op_e;

  typedef enum logic [1:0] {
    ST_BOOT    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_OPERAND = 2'd2,
    ST_MEM     = 2'd3
  } state_e;

  function automatic int unsigned addr_w(input int unsigned data_w);
    return data_w + NIB_W;
  endfunction

  // Instructions that read a second (operand) word.
  function automatic logic has_operand(input op_e op);
    return op inside {OP_LDI, OP_LD, OP_LDX, OP_ST, OP_STX, OP_JEQ, OP_JMP};
  endfunction

  function automatic logic is_mem(input op_e op);
    return op inside {OP_LD, OP_LDX, OP_ST, OP_STX};
  endfunction

  function automatic logic is_store(input op_e op);
    return op inside {OP_ST, OP_STX};
  endfunction

  function automatic logic is_indexed(input op_e op);
    return op inside {OP_LDX, OP_STX};
  endfunction

endpackage

// File: rtl/spis_alu.sv
// Combinational ALU for the single-word SPIS instructions; non-ALU opcodes pass state through.
module spis_alu
  import spis_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  op_e               op,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  input  logic [DATA_W-1:0] c_in,
  input  logic              cy_in,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output logic [DATA_W-1:0] c_out,
  output logic              cy_out
);

  localparam int unsigned SUM_W = DATA_W + 1;

  logic [SUM_W-1:0] sum;

  always_comb begin
    a_out  = a_in;
    b_out  = b_in;
    c_out  = c_in;
    cy_out = cy_in;
    sum    = '0;
    case (op)
      OP_ADD: sum = SUM_W'(a_in) + SUM_W'(b_in);
      OP_SUB: sum = SUM_W'(a_in) - SUM_W'(b_in);
      OP_ADC: sum = SUM_W'(a_in) + SUM_W'(b_in) + SUM_W'(cy_in);
      OP_SBC: sum = SUM_W'(a_in) - SUM_W'(b_in) - SUM_W'(cy_in);
      OP_XAB: begin a_out = b_in; b_out = a_in; end
      OP_XAC: begin a_out = c_in; c_out = a_in; end
      OP_NOT: a_out = ~a_in;
      OP_AND: a_out = a_in & b_in;
      OP_OR:  a_out = a_in | b_in;
      default: ;
    endcase
    // Carry (or borrow) is the extra top bit of the widened result.
    if (op inside {OP_ADD, OP_SUB, OP_ADC, OP_SBC}) begin
      a_out  = sum[DATA_W-1:0];
      cy_out = sum[SUM_W-1];
    end
  end

endmodule

// File: rtl/spis_core.sv
// Parametrised SPIS CPU with a req/ready memory bus.
// Optional retire trace ports are enabled with SPIS_TRACE_EN.
module spis_core
  import spis_pkg::*;
#(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned RESET_VECTOR = 0
) (
  input  logic                        clock,
  input  logic                        reset_n,
  output logic                        mem_req,
  output logic [addr_w(DATA_W)-1:0]   mem_addr,
  output logic                        mem_we,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata,
  input  logic                        mem_ready,
  output logic                        sync
`ifdef SPIS_TRACE_EN
  ,
  output logic                        trace_valid,
  output logic [addr_w(DATA_W)-1:0]   trace_ip,
  output logic [OP_W-1:0]             trace_op
`endif
);

  localparam int unsigned ADDR_W = addr_w(DATA_W);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d, c_q, c_d;
  logic                cy_q, cy_d;
  logic [ADDR_W-1:0]   ip_q, ip_d;
  op_e                 op_q, op_d;
  logic [NIB_W-1:0]    nib_q, nib_d;
  logic                req_d, we_d, sync_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [DATA_W-1:0]   wdata_d;

  op_e                 op_rd;
  logic [ADDR_W-1:0]   ip_inc, target, ea;
  logic [DATA_W-1:0]   alu_a, alu_b, alu_c;
  logic                alu_cy;

  assign op_rd  = op_e'(mem_rdata[DATA_W-1 -: OP_W]);
  assign ip_inc = ip_q + ADDR_W'(1);
  assign target = {nib_q, mem_rdata};
  assign ea     = is_indexed(op_q) ? target + ADDR_W'(c_q) : target;

  spis_alu #(.DATA_W(DATA_W)) u_alu (
    .op     (op_rd),
    .a_in   (a_q),
    .b_in   (b_q),
    .c_in   (c_q),
    .cy_in  (cy_q),
    .a_out  (alu_a),
    .b_out  (alu_b),
    .c_out  (alu_c),
    .cy_out (alu_cy)
  );

  // Next-state and next-bus decode; everything holds unless the current bus cycle completes.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    cy_d    = cy_q;
    ip_d    = ip_q;
    op_d    = op_q;
    nib_d   = nib_q;
    req_d   = mem_req;
    addr_d  = mem_addr;
    we_d    = mem_we;
    wdata_d = mem_wdata;
    sync_d  = sync;
    case (state_q)
      ST_BOOT: begin
        state_d = ST_FETCH;
        req_d   = 1'b1;
        addr_d  = ip_q;
        sync_d  = 1'b1;
      end
      ST_FETCH: if (mem_ready) begin
        op_d   = op_rd;
        nib_d  = mem_rdata[NIB_W-1:0];
        ip_d   = ip_inc;
        addr_d = ip_inc;
        if (has_operand(op_rd)) begin
          state_d = ST_OPERAND;
          sync_d  = 1'b0;
        end else begin
          a_d  = alu_a;
          b_d  = alu_b;
          c_d  = alu_c;
          cy_d = alu_cy;
        end
      end
      ST_OPERAND: if (mem_ready) begin
        ip_d    = ip_inc;
        addr_d  = ip_inc;
        state_d = ST_FETCH;
        sync_d  = 1'b1;
        if (is_mem(op_q)) begin
          state_d = ST_MEM;
          sync_d  = 1'b0;
          addr_d  = ea;
          we_d    = is_store(op_q);
          wdata_d = is_store(op_q) ? a_q : '0;
        end else begin
          if (op_q == OP_LDI) a_d = mem_rdata;
          if (op_q == OP_JMP || (op_q == OP_JEQ && a_q == b_q)) begin
            ip_d   = target;
            addr_d = target;
          end
        end
      end
      ST_MEM: if (mem_ready) begin
        state_d = ST_FETCH;
        addr_d  = ip_q;
        we_d    = 1'b0;
        wdata_d = '0;
        sync_d  = 1'b1;
        if (!is_store(op_q)) a_d = mem_rdata;
      end
      default: state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_BOOT;
      a_q       <= '0;
      b_q       <= '0;
      c_q       <= '0;
      cy_q      <= 1'b0;
      ip_q      <= ADDR_W'(RESET_VECTOR);
      op_q      <= OP_ADD;
      nib_q     <= '0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      sync      <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      c_q       <= c_d;
      cy_q      <= cy_d;
      ip_q      <= ip_d;
      op_q      <= op_d;
      nib_q     <= nib_d;
      mem_req   <= req_d;
      mem_addr  <= addr_d;
      mem_we    <= we_d;
      mem_wdata <= wdata_d;
      sync      <= sync_d;
    end
  end

`ifdef SPIS_TRACE_EN
  logic [ADDR_W-1:0] fetch_ip_q;
  logic              retire_c;

  // An instruction retires on the completing edge of its last bus cycle.
  assign retire_c = mem_ready && ((state_q == ST_MEM) ||
                    (state_q == ST_OPERAND && !is_mem(op_q)) ||
                    (state_q == ST_FETCH && !has_operand(op_rd)));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fetch_ip_q  <= '0;
      trace_valid <= 1'b0;
      trace_ip    <= '0;
      trace_op    <= '0;
    end else begin
      trace_valid <= retire_c;
      if (state_q == ST_FETCH && mem_ready) fetch_ip_q <= ip_q;
      if (retire_c) begin
        trace_ip <= (state_q == ST_FETCH) ? ip_q : fetch_ip_q;
        trace_op <= (state_q == ST_FETCH) ? OP_W'(op_rd) : OP_W'(op_q);
      end
    end
  end
`endif

endmodule

// File: tb/tb_spis_core.sv
// Directed bench for spis_core (DATA_W=8): runs a hand-assembled program against a
// memory model with wait-state control and checks the bus trace.
module tb_spis_core;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 12;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;
  logic          sync;
`ifdef SPIS_TRACE_EN
  logic          trace_valid;
  logic [AW-1:0] trace_ip;
  logic [3:0]    trace_op;
`endif

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] mem [0:4095];
  assign mem_rdata = mem_req ? mem[mem_addr] : '0;

  spis_core #(.DATA_W(DW), .RESET_VECTOR(0)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .sync      (sync)
`ifdef SPIS_TRACE_EN
    ,
    .trace_valid (trace_valid),
    .trace_ip    (trace_ip),
    .trace_op    (trace_op)
`endif
  );

  initial forever #5 clock = ~clock;

  // Bus monitor: completed writes and completed opcode fetches with their cycle stamp.
  int            cyc = 0;
  logic [AW-1:0] fq[$];
  int            fcq[$];
  logic [AW-1:0] wa[$];
  logic [DW-1:0] wd[$];

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (reset_n && mem_req && mem_ready) begin
      if (mem_we) begin
        wa.push_back(mem_addr);
        wd.push_back(mem_wdata);
      end else if (sync) begin
        fq.push_back(mem_addr);
        fcq.push_back(cyc);
      end
    end
  end

  logic [7:0] prog [0:73] = '{
    8'h50, 8'h05, 8'h41, 8'h50, 8'h07, 8'h10, 8'h80, 8'hF0, 8'h10, 8'h80,
    8'hF1, 8'h41, 8'h80, 8'hF2, 8'h20, 8'h80, 8'hF3, 8'h50, 8'h01, 8'h41,
    8'h50, 8'hFF, 8'h00, 8'h80, 8'hF4, 8'h41, 8'hA0, 8'h20, 8'h80, 8'hF5,
    8'h20, 8'h80, 8'hF6, 8'h50, 8'h10, 8'hA0, 8'h50, 8'h5A, 8'h93, 8'hF8,
    8'h50, 8'h01, 8'hA0, 8'h9F, 8'hFF, 8'h60, 8'hE0, 8'h80, 8'hF7, 8'h70,
    8'hE0, 8'h80, 8'hF8, 8'hD0, 8'h80, 8'hF9, 8'h50, 8'h0F, 8'h41, 8'hD0,
    8'hE0, 8'h80, 8'hFA, 8'h50, 8'h30, 8'hF0, 8'h80, 8'hFB, 8'hB1, 8'h23,
    8'h50, 8'h0F, 8'hB1, 8'h23
  };

  logic [AW-1:0] exp_f [0:50] = '{
    12'h000, 12'h002, 12'h003, 12'h005, 12'h006, 12'h008, 12'h009, 12'h00B, 12'h00C, 12'h00E,
    12'h00F, 12'h011, 12'h013, 12'h014, 12'h016, 12'h017, 12'h019, 12'h01A, 12'h01B, 12'h01C,
    12'h01E, 12'h01F, 12'h021, 12'h023, 12'h024, 12'h026, 12'h028, 12'h02A, 12'h02B, 12'h02D,
    12'h02F, 12'h031, 12'h033, 12'h035, 12'h036, 12'h038, 12'h03A, 12'h03B, 12'h03C, 12'h03D,
    12'h03F, 12'h041, 12'h042, 12'h044, 12'h046, 12'h048, 12'h123, 12'hFFE, 12'hFFF, 12'h050,
    12'h052
  };

  logic [AW-1:0] exp_wa [0:14] = '{
    12'h0F0, 12'h0F1, 12'h0F2, 12'h0F3, 12'h0F4, 12'h0F5, 12'h0F6, 12'h408,
    12'h000, 12'h0F7, 12'h0F8, 12'h0F9, 12'h0FA, 12'h0FB, 12'h0FC
  };
  logic [DW-1:0] exp_wd [0:14] = '{
    8'h02, 8'hFD, 8'h05, 8'h03, 8'h00, 8'h01, 8'h01, 8'h5A,
    8'h10, 8'hC3, 8'h3C, 8'hC3, 8'h0F, 8'h3F, 8'hF0
  };

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_req"},   32'(mem_req),   32'h0);
    chk({tag, "_we"},    32'(mem_we),    32'h0);
    chk({tag, "_addr"},  32'(mem_addr),  32'h0);
    chk({tag, "_wdata"}, 32'(mem_wdata), 32'h0);
    chk({tag, "_sync"},  32'(sync),      32'h0);
  endtask

  task automatic find_cycle(input logic [AW-1:0] a, input int limit, output bit found);
    found = 1'b0;
    for (int n = 0; n < limit && !found; n++) begin
      @(negedge clock);
      if (mem_req && !mem_we && !sync && mem_addr == a) found = 1'b1;
    end
  endtask

  bit found;
  int wc;
  int nf;

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    for (int i = 0; i < 74; i++) mem[i] = prog[i];
    mem[12'h123] = 8'hCF; mem[12'h124] = 8'hFE;
    mem[12'hFFE] = 8'hD0; mem[12'hFFF] = 8'hC0;
    mem[12'h050] = 8'h80; mem[12'h051] = 8'hFC;
    mem[12'h052] = 8'hC0; mem[12'h053] = 8'h52;
    mem[12'h0E0] = 8'hC3; mem[12'h0E1] = 8'h3C;

    mem_ready = 1'b1;
    reset_n   = 1'b1;
    #2 reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1 chk_idle("reset");

    // One BOOT clock after release, then the first fetch at the reset vector.
    @(negedge clock) reset_n = 1'b1;
    #1 chk("boot_req", 32'(mem_req), 32'h0);
    @(posedge clock);
    #1;
    chk("fetch0_req",  32'(mem_req),  32'h1);
    chk("fetch0_addr", 32'(mem_addr), 32'h000);
    chk("fetch0_sync", 32'(sync),     32'h1);

    // Stall the LD operand fetch for three clocks.
    find_cycle(12'h02E, 500, found);
    chk("find_ld_operand", 32'(found), 32'h1);
    mem_ready = 1'b0;
    repeat (3) begin
      @(posedge clock);
      #1;
      chk("stall_addr",  32'(mem_addr),  32'h02E);
      chk("stall_req",   32'(mem_req),   32'h1);
      chk("stall_sync",  32'(sync),      32'h0);
      chk("stall_wdata", 32'(mem_wdata), 32'h0);
    end
    @(negedge clock) mem_ready = 1'b1;

    nf = 0;
    while (fq.size() < 51 && nf < 2000) begin
      @(posedge clock);
      #1 nf++;
    end
    chk("prog_done", 32'(fq.size() >= 51), 32'h1);
    for (int i = 0; i < 51 && i < fq.size(); i++)
      chk($sformatf("fetch[%0d]", i), 32'(fq[i]), 32'(exp_f[i]));
    chk("write_count", 32'(wa.size()), 32'd15);
    for (int i = 0; i < 15 && i < wa.size(); i++) begin
      chk($sformatf("waddr[%0d]", i), 32'(wa[i]), 32'(exp_wa[i]));
      chk($sformatf("wdata[%0d]", i), 32'(wd[i]), 32'(exp_wd[i]));
    end
    if (fcq.size() >= 31) begin
      chk("lat_ldi",       32'(fcq[1] - fcq[0]),   32'd2);
      chk("lat_xab",       32'(fcq[2] - fcq[1]),   32'd1);
      chk("lat_st",        32'(fcq[5] - fcq[4]),   32'd3);
      chk("lat_ld_stall",  32'(fcq[30] - fcq[29]), 32'd6);
    end

    // Reset in the middle of an LD data cycle, then restart.
    @(negedge clock) reset_n = 1'b0;
    @(negedge clock);
    fq.delete(); fcq.delete(); wa.delete(); wd.delete();
    reset_n = 1'b1;
    find_cycle(12'h0E0, 500, found);
    chk("find_ld_mem", 32'(found), 32'h1);
    mem_ready = 1'b0;
    wc = wa.size();
    chk("writes_before_ld", 32'(wc), 32'd9);
    #3 reset_n = 1'b0;
    #1 chk_idle("mid_ld_reset");
    @(negedge clock);
    chk("no_write_in_reset", 32'(wa.size()), 32'(wc));
    mem_ready = 1'b1;
    fq.delete(); fcq.delete(); wa.delete(); wd.delete();
    reset_n = 1'b1;
    #1 chk("reboot_req", 32'(mem_req), 32'h0);
    @(posedge clock);
    #1;
    chk("refetch_req",  32'(mem_req),  32'h1);
    chk("refetch_addr", 32'(mem_addr), 32'h000);
    chk("refetch_sync", 32'(sync),     32'h1);

    nf = 0;
    while (wa.size() < 1 && nf < 500) begin
      @(posedge clock);
      #1 nf++;
    end
    chk("restart_write", 32'(wa.size() >= 1), 32'h1);
    if (wa.size() >= 1) begin
      chk("restart_waddr", 32'(wa[0]), 32'h0F0);
      chk("restart_wdata", 32'(wd[0]), 32'h02);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
